rx_fifo: RTL
============

Name: rx_fifo

Overview:
Input buffer that sits directly downstream of the per-port receive arbiter. The arbiter is a 5-way priority mux that writes one selected flit per cycle, gated by this block's full flag. rx_fifo stores flits in arrival order and presents them first-word-fall-through to the route/crossbar logic, which pops them with a read strobe. One instance is used per router output/input queue.

Parameters:
SIZE, 8, flit width in bits; must match the arbiter's item width.
DEPTH, 4, number of flit entries; power of two, at least 2.
AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
write  input  1  push strobe from the arbiter.
item_in  input  SIZE  flit to push; sampled when write=1.
full  output  1  no free entry; the arbiter gates write with it.
read  input  1  pop strobe from downstream.
valid  output  1  head entry present (not empty).
item_out  output  SIZE  head flit; valid whenever valid=1.
count  output  AW+1  number of occupied entries, 0..DEPTH.
overflow  output  1  sticky: write attempted while full.
underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset state:
  - Reset is asynchronous and active-high.
  - Pointers and count go to 0; full=0, valid=0, overflow=0, underflow=0.
  - item_out is don't-care (storage is not cleared).
- State: wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH), plus occupancy counter cnt (AW+1 bits).
- Flags:
  - full = (cnt==DEPTH); valid = (cnt!=0).
  - Both are decoded combinationally from registered cnt, so they are glitch-free relative to clk.
- Push accept: push = write & !full.
  - On accept: mem[wr_ptr] <= item_in; wr_ptr <= wr_ptr+1.
- Pop accept: pop = read & valid.
  - On accept: rd_ptr <= rd_ptr+1.
- Counter update:
  - cnt +1 on push only, -1 on pop only.
  - Unchanged on both or neither.
- Simultaneous push and pop, 0 < cnt < DEPTH: both happen, cnt unchanged.
- Empty (cnt=0):
  - A read is ignored and sets underflow.
  - A concurrent write is accepted; the flit becomes visible (valid=1) next cycle.
  - There is no same-cycle bypass.
- Full (cnt=DEPTH):
  - A write is ignored and sets overflow, even if read=1 in the same cycle.
  - A concurrent read is accepted, and full drops next cycle.
  - Rationale: the arbiter already masks write with full, so write-while-full is a protocol error.
- Output:
  - item_out = mem[rd_ptr], read combinationally: first-word fall-through.
  - It changes only after a clk edge on which a pop or a first push into an empty FIFO occurred.
- Latency:
  - Write to valid at head of an empty FIFO: 1 cycle.
  - read to next head: 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained.
- Wrap-around: pointers roll from DEPTH-1 to 0 naturally; no special case.
- Sticky flags: overflow and underflow clear only on reset.
- Reset mid-operation: all queued flits are discarded immediately (asynchronous); outputs take reset values within the same cycle.
- Registers: all state uses posedge clk or posedge reset; no latches.

Decomposition:
- Shared package/include:
  - SIZE default (8) with an `ifndef guard, as used by the arbiter.
  - Log2 helper function for AW.
  - FIFO default DEPTH constant.
- Sub-module rx_fifo_mem:
  - DEPTH x SIZE register file.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - No reset on the storage.
- rx_fifo keeps pointers, counter, flags and sticky error bits.

Test Plan:
1. Reset then push 8'hA1: valid=0 after reset; cycle after write, valid=1, item_out=8'hA1, count=1.
2. Push A1,B2,C3,D4 back-to-back (DEPTH=4): full=1 after the 4th edge, count=4. A 5th write of E5 is dropped and sets overflow=1. Pops return A1,B2,C3,D4 in order.
3. Fill to 2 entries, then hold write=1 and read=1 for 10 cycles with incrementing data: count stays 2, output sequence is in order, no flag set.
4. Wrap: push/pop 9 flits 00..08 one at a time: each appears at item_out 1 cycle after write, and pointers wrap twice without loss.
5. read with FIFO empty: underflow=1, count stays 0. Then write 5A with read=1 in the same cycle: 5A is accepted and valid=1 next cycle.
6. Full FIFO with read=1 and write=1 together: pop accepted, write dropped, overflow=1, count=3. Assert reset mid-cycle: count=0, valid=0, full=0, flags cleared without waiting for clk.

Source files
------------

// File: rtl/rx_fifo_pkg.sv
// Shared constants and helpers for the receive input buffer.
// Flit width is overridable at build time so it tracks the arbiter's item width.
`ifndef SIZE
`define SIZE 8
`endif

package rx_fifo_pkg;

    localparam int FLIT_SIZE  = `SIZE;
    localparam int FIFO_DEPTH = 4;

    // Smallest r such that 2**r >= n; sizes the FIFO pointers.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Purpose: DEPTH x SIZE register file, one sync write port, one async read port.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller decides when writes are legal.
module rx_fifo_mem #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    // Storage is deliberately not reset; occupancy tracking makes stale data harmless.
    logic [SIZE-1:0] mem [DEPTH];

    // Single write port, clocked.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// Purpose: in-order flit buffer between the receive arbiter and route/crossbar, FWFT output.
// Latency: write to head of empty FIFO 1 cycle; pop to next head 1 cycle; no bypass.
// Backpressure: full gates the arbiter; write-while-full / read-while-empty are dropped and latched sticky.
module rx_fifo
    import rx_fifo_pkg::*;
#(
    parameter int  SIZE  = FLIT_SIZE,
    parameter int  DEPTH = FIFO_DEPTH,
    localparam int AW    = log2_ceil(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write,
    input  logic [SIZE-1:0] item_in,
    output logic            full,
    input  logic            read,
    output logic            valid,
    output logic [SIZE-1:0] item_out,
    output logic [AW:0]     count,
    output logic            overflow,
    output logic            underflow
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    // Flags decode from the registered counter only, so they never glitch within a cycle.
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign valid = (cnt != '0);
    assign count = cnt;

    // A write while full is dropped even if a pop happens the same cycle.
    assign push = write & ~full;
    assign pop  = read & valid;

    // Pointers, occupancy and sticky protocol-error bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (write && full)   overflow  <= 1'b1;
            if (read && !valid)  underflow <= 1'b1;
        end
    end

    rx_fifo_mem #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (item_in),
        .raddr (rd_ptr),
        .rdata (item_out)
    );

endmodule
